bec_la_host_sequencer: RTL and testbench
========================================

Name: bec_la_host_sequencer

Overview:
- Host-side initiator for the BEC core's 128-bit logic-analyzer (LA) mailbox.
- Accepts seven 163-bit operands (A..F, H) on a valid/ready stream, then runs the full session over the LA bus: open, 14 half-word slot writes, process, 4 result reads, close.
- Presents the two 163-bit results (X, Z) on an output handshake.
- Sits between a management-side operand source and the LA pins that feed the BEC core.

Parameters:
- OPEN_WAIT, 2048: cycles the open command (0xAB40) is held before slot 1; must exceed the core's 2000-cycle update delay.
- CLOSE_WAIT, 2048: cycles the close command (0xAB10) is held.
- TIMEOUT, 65535: maximum cycles to wait for any single acknowledge or tag.
- TW, 16: width of the wait/timeout counter; must satisfy 2^TW-1 >= max(OPEN_WAIT, CLOSE_WAIT, TIMEOUT).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand word valid.
- in_ready  out  1  operand word accepted.
- in_data  in  163  operand, in order A,B,C,D,E,F,H.
- la_to_core  out  128  drives the core's la_data_in.
- la_oenb  out  128  0 = host driving; all-ones when idle.
- la_from_core  in  128  the core's la_data_out.
- out_valid  out  1  results valid.
- out_ready  in  1  results consumed.
- out_x  out  163  result X.
- out_z  out  163  result Z.
- busy  out  1  session in progress.
- err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset: state=IDLE.
  - Outputs: in_ready=0, la_to_core=0, la_oenb=all-ones, out_valid=0, out_x=out_z=0, busy=0, err=0.
  - Internals: operand count=0, wait counter=0.
  - Reset mid-session aborts immediately; no partial results are presented.
- LA field layout on la_to_core:
  - [31:16] command; [15:0]=0.
  - [95:82] slot thermometer; slot k (1..14) = low k bits set.
  - [81:0] payload.
  - [127:96]=0 always.
- Slot map:
  - Odd slot 2i-1 carries operand i bits [162:82] in payload[80:0], with payload[81]=0.
  - Even slot 2i carries operand i bits [81:0] in payload[81:0].
  - i=1..7 for A,B,C,D,E,F,H.
- Status fields on la_from_core:
  - Ack for slots 1..13: [125:122]==k.
  - Ack for slot 14: [127:122]==6'b011110.
  - Busy: [127:122]==6'b100111.
  - Read tags: [127:120].
  - Read payload: [113:32], 82 bits.
- State machine:
  - IDLE: la_oenb all-ones, in_ready=0. Enter LOAD when in_valid=1.
  - LOAD: in_ready=1. Each in_valid&&in_ready stores in_data into buffer[count] and increments count. After the 7th word: in_ready=0 on the next cycle, then OPEN.
  - OPEN: la_oenb=0, cmd=0xAB40, slot=0. Hold exactly OPEN_WAIT cycles, then SLOT with k=1.
  - SLOT: cmd=0x0000; drive slot k thermometer and payload.
    - The ack is sampled registered. On ack: k+1 next cycle, payload updated in the same cycle.
    - After the slot-14 ack: PROC.
  - PROC: cmd=0xAB41, slot=0, payload=0.
    - First wait for busy status, then wait for busy to deassert.
    - Each wait phase has its own TIMEOUT. Then READ with r=0.
  - READ: cmd=0xAB00|{r,2'b00}<<0, giving 0xAB00, 0xAB04, 0xAB08, 0xAB0C for r=0..3.
    - On tag == 0xC4+4r, capture la_from_core[113:32] into word r.
    - After r=3: CLOSE.
  - CLOSE: cmd=0xAB10 for CLOSE_WAIT cycles. Then la_to_core=0, la_oenb all-ones, and DONE.
  - DONE: out_valid=1 and results held stable. On out_valid&&out_ready: out_valid=0 next cycle, then IDLE.
- Result assembly:
  - X = {word0[81:0], word1[80:0]}.
  - Z = {word2[81:0], word3[80:0]}.
  - Bit 81 of words 1 and 3 is ignored.
  - out_x/out_z update only on DONE entry.
- Timeout:
  - The wait counter resets on every state, slot, or read index change.
  - Reaching TIMEOUT in SLOT, PROC or READ: err=1 for one cycle, la_to_core=0, la_oenb all-ones, IDLE.
  - The operand buffer is discarded; out_valid stays 0.
- busy=1 in every state except IDLE and DONE.
- in_valid during OPEN through DONE is ignored (in_ready=0).
- An ack arriving in the same cycle as TIMEOUT expiry counts as success; ack has priority.
- A stale ack already present when a slot is first driven is accepted.
  - This is legal: the core's ack value is unique per slot, so a stale ack for slot k cannot equal slot k+1's value.

Test Plan:
- Reset, then push A..H = 163'h1..163'h7 → la_oenb=0 from OPEN; 0xAB40 held exactly 2048 cycles; slot 1 drives [95:82]=14'h0001 with payload[80:0]=A[162:82]=0.
- Responder model acks each slot after 3 cycles → 14 slots in order, thermometers 0x0001..0x3FFF; slot 2 payload=82'h1, slot 14 payload=82'h7; advance only after the correct ack.
- Model returns busy for 10 cycles, then tags C4/C8/CC/D0 with payloads 82'h3FFFF..., 82'h1, 82'h2, 82'h155 → out_x={word0, word1[80:0]}, out_z likewise; out_valid held until out_ready.
- out_ready held low for 50 cycles → results stable, no new session starts; pulse out_ready → IDLE, la_oenb=all-ones.
- Model withholds the slot-5 ack → err pulses exactly once at TIMEOUT, state returns to IDLE, out_valid stays 0, la_to_core=0.
- Assert rst during READ r=2 → all outputs at reset values next cycle; a new 7-operand push completes a clean session.

Source files
------------

// File: rtl/bec_la_host_sequencer_if.sv
// Operand stream, result stream and LA mailbox pins between the host sequencer and its environment.
// master = sequencer side, slave = operand source / core / result sink side.
interface bec_la_host_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [162:0] in_data;
    logic [127:0] la_to_core;
    logic [127:0] la_oenb;
    logic [127:0] la_from_core;
    logic         out_valid;
    logic         out_ready;
    logic [162:0] out_x;
    logic [162:0] out_z;

    modport master (
        input  in_valid, in_data, la_from_core, out_ready,
        output in_ready, la_to_core, la_oenb, out_valid, out_x, out_z
    );
    modport slave (
        output in_valid, in_data, la_from_core, out_ready,
        input  in_ready, la_to_core, la_oenb, out_valid, out_x, out_z
    );
endinterface

// File: rtl/bec_la_host_sequencer.sv
// Host-side initiator for the BEC core LA mailbox: loads seven operands, runs
// open / 14 slot writes / process / 4 reads / close, then presents X and Z.
module bec_la_host_sequencer #(
    parameter int OPEN_WAIT  = 2048,
    parameter int CLOSE_WAIT = 2048,
    parameter int TIMEOUT    = 65535,
    parameter int TW         = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    bec_la_host_sequencer_if.master bus,
    output logic                    busy,
    output logic                    err
);
    localparam logic [TW-1:0] OPEN_LAST   = TW'(OPEN_WAIT - 1);
    localparam logic [TW-1:0] CLOSE_LAST  = TW'(CLOSE_WAIT - 1);
    localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_OPEN, S_SLOT, S_PROC, S_READ, S_CLOSE, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  cnt_q, cnt_d;
    logic [2:0]     count_q, count_d;
    logic [3:0]     slot_q, slot_d;
    logic [1:0]     rd_q, rd_d;
    logic           phase_q, phase_d;
    logic           err_q, err_d;
    logic [127:0]   status_q;
    logic [162:0]   x_q, x_d, z_q, z_d;
    logic [162:0]   buf_q [7];
    logic [81:0]    word_q [4];
    logic           load_we, word_we;

    logic [15:0]    cmd;
    logic [13:0]    therm, therm_w;
    logic [81:0]    payload;
    logic [3:0]     slot_m1;
    logic [162:0]   operand;
    logic           slot_ack, core_busy, tag_hit;
    logic           unused_status;

    for (genvar gi = 0; gi < 14; gi++) begin : g_therm
        assign therm_w[gi] = (slot_q > 4'(gi));
    end

    // Slots 2i-1 and 2i both carry operand i, so the operand index is (k-1)/2.
    assign slot_m1   = slot_q - 4'd1;
    assign operand   = buf_q[slot_m1[3:1]];
    assign slot_ack  = (slot_q == 4'd14) ? (status_q[127:122] == 6'b011110)
                                         : (status_q[125:122] == slot_q);
    assign core_busy = (status_q[127:122] == 6'b100111);
    assign tag_hit   = (status_q[127:120] == (8'hC4 + {4'h0, rd_q, 2'b00}));
    assign unused_status = ^{status_q[119:114], status_q[31:0], word_q[1][81], word_q[3][81]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + TW'(1);
        count_d = count_q;
        slot_d  = slot_q;
        rd_d    = rd_q;
        phase_d = phase_q;
        err_d   = 1'b0;
        x_d     = x_q;
        z_d     = z_q;
        load_we = 1'b0;
        word_we = 1'b0;
        bus.in_ready = 1'b0;
        bus.la_oenb  = '1;
        cmd     = 16'h0000;
        therm   = 14'h0;
        payload = 82'h0;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                count_d = 3'd0;
                if (bus.in_valid) state_d = S_LOAD;
            end
            S_LOAD: begin
                cnt_d = '0;
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    load_we = 1'b1;
                    count_d = count_q + 3'd1;
                    if (count_q == 3'd6) state_d = S_OPEN;
                end
            end
            S_OPEN: begin
                bus.la_oenb = '0;
                cmd = 16'hAB40;
                if (cnt_q == OPEN_LAST) begin
                    state_d = S_SLOT;
                    slot_d  = 4'd1;
                    cnt_d   = '0;
                end
            end
            S_SLOT: begin
                bus.la_oenb = '0;
                therm   = therm_w;
                payload = slot_q[0] ? {1'b0, operand[162:82]} : operand[81:0];
                // An ack in the expiry cycle still wins over the timeout.
                if (slot_ack) begin
                    cnt_d = '0;
                    if (slot_q == 4'd14) begin
                        state_d = S_PROC;
                        phase_d = 1'b0;
                    end else begin
                        slot_d = slot_q + 4'd1;
                    end
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_PROC: begin
                bus.la_oenb = '0;
                cmd = 16'hAB41;
                if (!phase_q && core_busy) begin
                    phase_d = 1'b1;
                    cnt_d   = '0;
                end else if (phase_q && !core_busy) begin
                    state_d = S_READ;
                    rd_d    = 2'd0;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_READ: begin
                bus.la_oenb = '0;
                cmd = 16'hAB00 | {12'h000, rd_q, 2'b00};
                if (tag_hit) begin
                    word_we = 1'b1;
                    cnt_d   = '0;
                    if (rd_q == 2'd3) state_d = S_CLOSE;
                    else              rd_d = rd_q + 2'd1;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_CLOSE: begin
                bus.la_oenb = '0;
                cmd = 16'hAB10;
                if (cnt_q == CLOSE_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    x_d     = {word_q[0], word_q[1][80:0]};
                    z_d     = {word_q[2], word_q[3][80:0]};
                end
            end
            S_DONE: begin
                cnt_d = '0;
                if (bus.out_ready) state_d = S_IDLE;
            end
        endcase
    end

    // Command and payload never overlap in use: slot writes carry cmd 0, others carry payload 0.
    assign bus.la_to_core = {32'h0, therm, payload} | {96'h0, cmd, 16'h0};
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.out_x      = x_q;
    assign bus.out_z      = z_q;
    assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
    assign err            = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            count_q  <= 3'd0;
            slot_q   <= 4'd0;
            rd_q     <= 2'd0;
            phase_q  <= 1'b0;
            err_q    <= 1'b0;
            status_q <= '0;
            x_q      <= '0;
            z_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            count_q  <= count_d;
            slot_q   <= slot_d;
            rd_q     <= rd_d;
            phase_q  <= phase_d;
            err_q    <= err_d;
            status_q <= bus.la_from_core;
            x_q      <= x_d;
            z_q      <= z_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_we) buf_q[count_q] <= bus.in_data;
        if (word_we) word_q[rd_q] <= status_q[113:32];
    end
endmodule

// File: tb/tb_bec_la_host_sequencer.sv
// Directed-plus-random sessions against a responder and a spec-level model of the LA mailbox.
module tb_bec_la_host_sequencer;
    localparam int OPEN_W  = 2048;
    localparam int CLOSE_W = 2048;
    localparam int TO      = 1000;
    localparam logic [127:0] ALL_ONES = {128{1'b1}};

    logic clk = 1'b0;
    logic rst;
    logic busy, err;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [162:0] ops [7];
    logic [81:0]  words [4];

    bec_la_host_sequencer_if bus ();

    bec_la_host_sequencer #(.OPEN_WAIT(OPEN_W), .CLOSE_WAIT(CLOSE_W), .TIMEOUT(TO), .TW(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [162:0] rand163();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[162:0];
    endfunction

    function automatic logic [81:0] rand82();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[81:0];
    endfunction

    // Expected LA word for a slot write, straight from the field layout.
    function automatic logic [127:0] slot_word(input int k);
        logic [127:0] w;
        logic [162:0] op;
        w = '0;
        op = ops[(k - 1) / 2];
        w[95:82] = 14'((1 << k) - 1);
        if (k % 2 == 1) w[80:0] = op[162:82];
        else            w[81:0] = op[81:0];
        return w;
    endfunction

    function automatic logic [127:0] cmd_word(input logic [15:0] c);
        logic [127:0] w;
        w = '0;
        w[31:16] = c;
        return w;
    endfunction

    function automatic logic [127:0] ack_word(input int k);
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        if (k == 14) w[127:122] = 6'b011110;
        else begin
            w[127:126] = 2'b00;
            w[125:122] = 4'(k);
        end
        return w;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
        chk({tag, "_la_to_core"}, bus.la_to_core, 128'h0);
        chk({tag, "_la_oenb"}, bus.la_oenb, ALL_ONES);
        chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic push_ops();
        int guard;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.in_data = ops[i];
            guard = 0;
            while (!bus.in_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            chk("push_ready", bus.in_ready, 1'b1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic run_session(input bit fixed, input int withhold, input int reset_read, input int hold);
        int n;
        int guard;
        int err_cnt;
        logic [162:0] ex, ez;
        logic [127:0] w;
        for (int i = 0; i < 7; i++) ops[i] = fixed ? 163'(i + 1) : rand163();
        if (fixed) begin
            words[0] = {82{1'b1}};
            words[1] = 82'h1;
            words[2] = 82'h2;
            words[3] = 82'h155;
        end else begin
            for (int r = 0; r < 4; r++) words[r] = rand82();
        end
        bus.la_from_core = '0;
        push_ops();

        chk("open_in_ready", bus.in_ready, 1'b0);
        chk("open_oenb", bus.la_oenb, 128'h0);
        chk("open_busy", busy, 1'b1);
        chk("open_word", bus.la_to_core, cmd_word(16'hAB40));
        n = 0;
        while (bus.la_to_core == cmd_word(16'hAB40) && n < 3 * OPEN_W) begin
            n++;
            @(negedge clk);
        end
        chk("open_cycles", n, OPEN_W);

        for (int k = 1; k <= 14; k++) begin
            chk($sformatf("slot%0d_word", k), bus.la_to_core, slot_word(k));
            chk($sformatf("slot%0d_oenb", k), bus.la_oenb, 128'h0);
            if (k == withhold) begin
                guard = 0;
                while (!err && guard < TO + 20) begin
                    @(negedge clk);
                    guard++;
                end
                chk("timeout_err_seen", err, 1'b1);
                chk("timeout_latency", (guard >= TO) && (guard <= TO + 3), 1'b1);
                check_idle_outputs("timeout");
                err_cnt = 0;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (err) err_cnt++;
                end
                chk("timeout_err_single", err_cnt, 0);
                chk("timeout_out_valid", bus.out_valid, 1'b0);
                return;
            end
            repeat (3) @(negedge clk);
            chk($sformatf("slot%0d_waits_ack", k), bus.la_to_core, slot_word(k));
            bus.la_from_core = ack_word(k);
            guard = 0;
            while (bus.la_to_core[95:82] == 14'((1 << k) - 1) && guard < 10) begin
                @(negedge clk);
                guard++;
            end
            chk($sformatf("slot%0d_advance", k), guard < 10, 1'b1);
        end

        chk("proc_word", bus.la_to_core, cmd_word(16'hAB41));
        bus.la_from_core = {6'b100111, 122'h0} | {6'h0, rand82(), 40'h0};
        repeat (10) @(negedge clk);
        chk("proc_held_busy", bus.la_to_core, cmd_word(16'hAB41));
        bus.la_from_core = '0;
        guard = 0;
        while (bus.la_to_core == cmd_word(16'hAB41) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("proc_exit", guard < 20, 1'b1);

        for (int r = 0; r < 4; r++) begin
            chk($sformatf("read%0d_word", r), bus.la_to_core, cmd_word(16'hAB00 + 16'(4 * r)));
            if (r == reset_read) begin
                rst = 1'b1;
                @(negedge clk);
                check_idle_outputs("reset_mid");
                chk("reset_mid_err", err, 1'b0);
                chk("reset_mid_out_x", bus.out_x, 163'h0);
                chk("reset_mid_out_z", bus.out_z, 163'h0);
                rst = 1'b0;
                bus.la_from_core = '0;
                @(negedge clk);
                return;
            end
            repeat (2) @(negedge clk);
            w = {$urandom, $urandom, $urandom, $urandom};
            w[127:120] = 8'(8'hC4 + 4 * r);
            w[113:32]  = words[r];
            bus.la_from_core = w;
            guard = 0;
            while (bus.la_to_core == cmd_word(16'hAB00 + 16'(4 * r)) && guard < 10) begin
                @(negedge clk);
                guard++;
            end
            chk($sformatf("read%0d_advance", r), guard < 10, 1'b1);
        end

        bus.la_from_core = '0;
        n = 0;
        while (bus.la_to_core == cmd_word(16'hAB10) && n < 3 * CLOSE_W) begin
            n++;
            @(negedge clk);
        end
        chk("close_cycles", n, CLOSE_W);

        ex = {words[0], words[1][80:0]};
        ez = {words[2], words[3][80:0]};
        chk("done_out_valid", bus.out_valid, 1'b1);
        chk("done_out_x", bus.out_x, ex);
        chk("done_out_z", bus.out_z, ez);
        chk("done_la_to_core", bus.la_to_core, 128'h0);
        chk("done_oenb", bus.la_oenb, ALL_ONES);
        chk("done_busy", busy, 1'b0);
        chk("done_err", err, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = rand163();
        repeat (hold) @(negedge clk);
        chk("hold_out_valid", bus.out_valid, 1'b1);
        chk("hold_out_x", bus.out_x, ex);
        chk("hold_out_z", bus.out_z, ez);
        chk("hold_in_ready", bus.in_ready, 1'b0);
        chk("hold_busy", busy, 1'b0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_idle_outputs("after_done");
        @(negedge clk);
        check_idle_outputs("idle_settled");
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.la_from_core = '0;
        bus.out_ready    = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        chk("reset_err", err, 1'b0);
        chk("reset_out_x", bus.out_x, 163'h0);
        chk("reset_out_z", bus.out_z, 163'h0);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        run_session(1'b1, 0, -1, 50);
        $display("session fixed operands: done");
        run_session(1'b0, 5, -1, 0);
        $display("session slot-5 ack withheld: done");
        run_session(1'b0, 0, 2, 0);
        $display("session reset during read 2: done");
        run_session(1'b0, 0, -1, 3);
        $display("session clean after reset: done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
